md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit in the EXE stage, with HI/LO registers.
- Consumes the instruction and operands produced by the ID/EXE pipeline register: instr_E, RD1_E (rs) and RD2_E (rt).
- Executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency, and services MFHI/MFLO/MTHI/MTLO.
- Exports a busy indication so the hazard unit can stall the ID stage.

Parameters:
- MULT_CYCLES, 5, cycles from a multiply start until HI/LO is updated (1..15).
- DIV_CYCLES, 10, cycles from a divide start until HI/LO is updated (1..15).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- instr_E  in  32  instruction currently in EXE; 0 is a bubble/NOP.
- RD1_E  in  32  rs operand (forwarded value).
- RD2_E  in  32  rt operand (forwarded value).
- md_out  out  32  HI for MFHI, LO for MFLO, otherwise 0; combinational.
- md_start  out  1  instr_E is MULT/MULTU/DIV/DIVU and the unit is idle; combinational.
- md_busy  out  1  md_start OR internal counter != 0.
- hi_q  out  32  architectural HI register.
- lo_q  out  32  architectural LO register.

Behaviour:
- Decode:
  - opcode (instr_E[31:26]) == 6'h00 with funct: MULT 18, MULTU 19, DIV 1A, DIVU 1B, MFHI 10, MTHI 11, MFLO 12, MTLO 13 (hex).
  - All other encodings are non-MD and have no effect.
- Reset: while reset==0, asynchronously clear HI, LO, pend_hi, pend_lo and cnt to 0. md_busy=0; md_out=0 unless an MFHI/MFLO is present.
- State: cnt[3:0] with two states.
  - IDLE: cnt==0.
  - BUSY: cnt!=0.
- Start, on the edge where md_start==1:
  - cnt <= MULT_CYCLES or DIV_CYCLES.
  - pend_hi/pend_lo <= full result computed from RD1_E/RD2_E sampled at that edge.
- BUSY:
  - Each edge cnt decrements.
  - On the edge where cnt==1: HI<=pend_hi, LO<=pend_lo, cnt<=0.
  - The new HI/LO value is visible exactly N cycles after the start edge.
- Arithmetic:
  - MULT: signed 32x32 -> 64, HI = [63:32], LO = [31:0].
  - MULTU: unsigned 32x32 -> 64, same split.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (rt==0): LO=32'hFFFFFFFF, HI=rs (DIV and DIVU).
  - DIV 0x80000000 / 0xFFFFFFFF: LO=32'h80000000, HI=0.
- MTHI/MTLO:
  - Write RD1_E into HI/LO at the edge, only while IDLE.
  - While BUSY, the write is ignored.
- MFHI/MFLO:
  - md_out returns the current HI/LO combinationally.
  - While BUSY it returns the stale value; the hazard unit must stall any MD instruction in ID while md_busy==1.
- Protocol:
  - A start-type instruction arriving while BUSY is ignored (no restart, no pending update). This is a hazard-unit bug; assertion only.
- Reset mid-operation: the pending result is discarded; HI/LO read 0 afterwards.
- Bubble (instr_E==0): no effect in any state.

Optional Feature:
- MD_MADD_EN: when defined, decode opcode 6'h1C (SPECIAL2) with funct:
  - MADD 00, MADDU 01: {HI,LO} += product.
  - MSUB 04, MSUBU 05: {HI,LO} -= product.
  - The accumulate uses the HI/LO values at the start edge, wraps modulo 2^64, and takes MULT_CYCLES.
- Without the macro, these encodings are non-MD and have no effect.

Decomposition:
- Shared package md_defs: opcode/funct localparams and the MD operation enum (NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU).
- One sub-module md_decode: combinational instr_E -> operation enum, used by both md_unit and the hazard unit.

Test Plan:
- MULT rs=7, rt=32'hFFFFFFFD:
  - md_busy high for 6 cycles (start cycle plus 5).
  - After 5 cycles HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
  - MFHI in the start cycle returns the old HI.
- DIVU 100/7: LO=14, HI=2 exactly 10 cycles after start. DIV -7/2: LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIV rs=5, rt=0: LO=32'hFFFFFFFF, HI=5. DIV 0x80000000/-1: LO=32'h80000000, HI=0.
- MTHI 32'hA5A5A5A5 while idle, then MFHI next cycle: md_out=32'hA5A5A5A5. MTLO issued during a MULT busy window: LO is ignored and receives the product.
- Start DIVU, pull reset low at cnt==4: cnt=0, md_busy=0 immediately, HI=LO=0; after release no late commit occurs.
- MD_MADD_EN: HI/LO={0,32'hFFFFFFFF}, MADDU 1*1: after 5 cycles HI=1, LO=0.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: opcode/funct encodings and the MD operation enum.
// The SPECIAL2 accumulate encodings are only decoded when MD_MADD_EN is defined.
package md_defs;

   localparam logic [5:0] OPC_SPECIAL  = 6'h00;
   localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   localparam logic [5:0] FN_MADD  = 6'h00;
   localparam logic [5:0] FN_MADDU = 6'h01;
   localparam logic [5:0] FN_MSUB  = 6'h04;
   localparam logic [5:0] FN_MSUBU = 6'h05;

   typedef enum logic [3:0] {
      OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
   } md_op_e;

   // Multiply-class operations all take MULT_CYCLES.
   function automatic logic is_mult_op(md_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
             (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic is_start_op(md_op_e op);
      return is_mult_op(op) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_unit_decode.sv
// md_decode: combinational instr_E -> MD operation, shared with the hazard unit.
// Decodes SPECIAL2 MADD/MADDU/MSUB/MSUBU only when MD_MADD_EN is defined.
module md_decode
   import md_defs::*;
(
   input  logic [31:0] instr,
   output md_op_e      op
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_fields;

   assign opcode        = instr[31:26];
   assign funct         = instr[5:0];
   assign unused_fields = ^instr[25:6];

   always_comb begin
      op = OP_NONE;
      if (opcode == OPC_SPECIAL) begin
         case (funct)
            FN_MULT:  op = OP_MULT;
            FN_MULTU: op = OP_MULTU;
            FN_DIV:   op = OP_DIV;
            FN_DIVU:  op = OP_DIVU;
            FN_MFHI:  op = OP_MFHI;
            FN_MFLO:  op = OP_MFLO;
            FN_MTHI:  op = OP_MTHI;
            FN_MTLO:  op = OP_MTLO;
            default:  op = OP_NONE;
         endcase
      end
`ifdef MD_MADD_EN
      else if (opcode == OPC_SPECIAL2) begin
         case (funct)
            FN_MADD:  op = OP_MADD;
            FN_MADDU: op = OP_MADDU;
            FN_MSUB:  op = OP_MSUB;
            FN_MSUBU: op = OP_MSUBU;
            default:  op = OP_NONE;
         endcase
      end
`endif
   end

endmodule

// File: rtl/md_unit.sv
// md_unit: EXE-stage multiply/divide unit with HI/LO, fixed-latency MULT/DIV and busy export.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MD_MADD_EN.
module md_unit
   import md_defs::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_E,
   input  logic [31:0] RD1_E,
   input  logic [31:0] RD2_E,
   output logic [31:0] md_out,
   output logic        md_start,
   output logic        md_busy,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   md_op_e      op;
   logic [3:0]  cnt;
   logic [31:0] pend_hi;
   logic [31:0] pend_lo;
   logic [63:0] result;
   logic        idle;

   md_decode u_decode (
      .instr (instr_E),
      .op    (op)
   );

   // Full {HI,LO} result; the accumulate forms fold in the HI/LO seen at the start edge.
   function automatic logic [63:0] md_result(md_op_e f_op, logic [31:0] rs,
                                              logic [31:0] rt, logic [63:0] acc);
      logic signed [63:0] prod_s;
      logic        [63:0] prod_u;
      logic signed [31:0] quo_s;
      logic signed [31:0] rem_s;
      prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
      prod_u = {32'd0, rs} * {32'd0, rt};
      quo_s  = '0;
      rem_s  = '0;
      md_result = '0;
      case (f_op)
         OP_MULT:  md_result = $unsigned(prod_s);
         OP_MULTU: md_result = prod_u;
         OP_MADD:  md_result = acc + $unsigned(prod_s);
         OP_MADDU: md_result = acc + prod_u;
         OP_MSUB:  md_result = acc - $unsigned(prod_s);
         OP_MSUBU: md_result = acc - prod_u;
         OP_DIV: begin
            if (rt == 32'd0)
               md_result = {rs, 32'hFFFF_FFFF};
            else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF)
               md_result = {32'd0, 32'h8000_0000};
            else begin
               quo_s = $signed(rs) / $signed(rt);
               rem_s = $signed(rs) % $signed(rt);
               md_result = {$unsigned(rem_s), $unsigned(quo_s)};
            end
         end
         OP_DIVU: begin
            if (rt == 32'd0)
               md_result = {rs, 32'hFFFF_FFFF};
            else
               md_result = {rs % rt, rs / rt};
         end
         default:  md_result = '0;
      endcase
   endfunction

   assign idle     = (cnt == 4'd0);
   assign md_start = is_start_op(op) && idle;
   assign md_busy  = md_start || !idle;
   assign result   = md_result(op, RD1_E, RD2_E, {hi_q, lo_q});

   always_comb begin
      md_out = '0;
      case (op)
         OP_MFHI: md_out = hi_q;
         OP_MFLO: md_out = lo_q;
         default: md_out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else if (md_start) begin
         cnt                <= is_mult_op(op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
         {pend_hi, pend_lo} <= result;
      end else if (!idle) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            hi_q <= pend_hi;
            lo_q <= pend_lo;
         end
      end else begin
         if (op == OP_MTHI) hi_q <= RD1_E;
         if (op == OP_MTLO) lo_q <= RD1_E;
      end
   end

   // A start while busy means the hazard unit let an MD op through; it is dropped.
   always_ff @(posedge clk) begin
      if (reset && !idle)
         assert (!is_start_op(op)) else $error("md_unit: MD start issued while busy");
   end

endmodule
